control_seq_ws: RTL and testbench

- Parametrised successor to the VeriRISC instruction-sequencing controller.
- Generates the seven datapath strobes per opcode and phase, like the existing controller.
- Adds memory wait-state insertion (static count plus optional `mem_ready` handshake), a held HALTED state with resume, and single-step pause.
- Sits between the instruction register/ALU `zero` flag and the memory, PC, AC and IR load enables.

---
 rtl/control_seq_ws_pkg.sv | 49 ++++
 rtl/control_seq_ws_wait_cnt.sv | 38 +++
 rtl/control_seq_ws.sv | 119 +++++++++++
 tb/tb_control_seq_ws.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/control_seq_ws_pkg.sv
// Shared types for the wait-state capable instruction-sequencing controller.
//   opcode_t     : 3-bit VeriRISC opcode
//   ctrl_state_t : controller phase, exported on the phase debug port
//   strobes_t    : the seven datapath strobes as one payload
//   is_aluop     : opcodes whose result comes from memory via the ALU
package control_seq_ws_pkg;

  localparam int unsigned OPCODE_W = 3;
  localparam int unsigned STATE_W  = 4;

  typedef enum logic [OPCODE_W-1:0] {
    HLT = 3'd0,
    SKZ = 3'd1,
    ADD = 3'd2,
    AND = 3'd3,
    XOR = 3'd4,
    LDA = 3'd5,
    STO = 3'd6,
    JMP = 3'd7
  } opcode_t;

  typedef enum logic [STATE_W-1:0] {
    INST_ADDR  = 4'd0,
    INST_FETCH = 4'd1,
    INST_LOAD  = 4'd2,
    IDLE       = 4'd3,
    OP_ADDR    = 4'd4,
    OP_FETCH   = 4'd5,
    ALU_OP     = 4'd6,
    STORE      = 4'd7,
    HALTED     = 4'd8,
    PAUSED     = 4'd9
  } ctrl_state_t;

  typedef struct packed {
    logic mem_rd;
    logic load_ir;
    logic halt;
    logic inc_pc;
    logic load_ac;
    logic load_pc;
    logic mem_wr;
  } strobes_t;

  function automatic logic is_aluop(opcode_t op);
    return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
  endfunction

endpackage

// File: rtl/control_seq_ws_wait_cnt.sv
// Fetch-phase wait-state counter, shared by INST_FETCH and OP_FETCH.
//   clk, rst_   : clock, async active-low reset
//   load        : reload with MEM_WAIT (entry into a fetch phase)
//   en          : count down while in a fetch phase
//   mem_ready   : memory data valid, only consulted when USE_READY=1
//   expired_c   : combinational; fetch phase may exit this cycle
module ctrl_wait_cnt
  import control_seq_ws_pkg::*;
#(
  parameter int unsigned MEM_WAIT  = 0,
  parameter int unsigned USE_READY = 0,
  parameter int unsigned CNT_W     = 4
) (
  input  logic clk,
  input  logic rst_,
  input  logic load,
  input  logic en,
  input  logic mem_ready,
  output logic expired_c
);

  logic [CNT_W-1:0] cnt_q;

  // Down-counter: reload wins, otherwise decrement and stick at zero.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= CNT_W'(MEM_WAIT);
    end else if (en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  // Static wait done, and memory ready when the handshake is in use.
  assign expired_c = (cnt_q == '0) && ((USE_READY == 0) || mem_ready);

endmodule

// File: rtl/control_seq_ws.sv
// VeriRISC instruction-sequencing controller with memory wait states,
// held HALTED state with resume, and single-step pause.
//   clk, rst_          : clock, async active-low reset
//   opcode, zero       : current instruction opcode, accumulator-zero flag
//   mem_ready          : memory data valid (used when USE_READY=1)
//   resume             : leaves HALTED or PAUSED
//   step_mode          : pause after each completed instruction
//   mem_rd .. mem_wr   : registered datapath strobes
//   phase              : current controller state
//   instr_done         : one-cycle pulse during STORE
module control_seq_ws
  import control_seq_ws_pkg::*;
#(
  parameter int unsigned MEM_WAIT  = 0,
  parameter int unsigned USE_READY = 0,
  parameter int unsigned CNT_W     = 4
) (
  input  logic        clk,
  input  logic        rst_,
  input  opcode_t     opcode,
  input  logic        zero,
  input  logic        mem_ready,
  input  logic        resume,
  input  logic        step_mode,
  output logic        mem_rd,
  output logic        load_ir,
  output logic        halt,
  output logic        inc_pc,
  output logic        load_ac,
  output logic        load_pc,
  output logic        mem_wr,
  output ctrl_state_t phase,
  output logic        instr_done
);

  ctrl_state_t state_q, state_d;
  strobes_t    strb_q, strb_d;
  logic        done_q, done_d;
  logic        in_fetch_c, wait_load_c, expired_c;

  assign in_fetch_c  = (state_q == INST_FETCH) || (state_q == OP_FETCH);
  assign wait_load_c = ((state_d == INST_FETCH) || (state_d == OP_FETCH)) &&
                       (state_d != state_q);

  ctrl_wait_cnt #(
    .MEM_WAIT (MEM_WAIT),
    .USE_READY(USE_READY),
    .CNT_W    (CNT_W)
  ) u_wait_cnt (
    .clk      (clk),
    .rst_     (rst_),
    .load     (wait_load_c),
    .en       (in_fetch_c),
    .mem_ready(mem_ready),
    .expired_c(expired_c)
  );

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      INST_ADDR:  state_d = INST_FETCH;
      INST_FETCH: if (expired_c) state_d = INST_LOAD;
      INST_LOAD:  state_d = IDLE;
      IDLE:       state_d = OP_ADDR;
      OP_ADDR:    state_d = (opcode == HLT) ? HALTED : OP_FETCH;
      OP_FETCH:   if (expired_c) state_d = ALU_OP;
      ALU_OP:     state_d = STORE;
      STORE:      state_d = step_mode ? PAUSED : INST_ADDR;
      HALTED,
      PAUSED:     if (resume) state_d = INST_ADDR;
      default:    state_d = INST_ADDR;
    endcase
  end

  // Strobe decode for the state being entered, so outputs can be registered.
  always_comb begin
    logic aluop;
    aluop  = is_aluop(opcode);
    strb_d = '0;
    strb_d.mem_rd  = (state_d == INST_FETCH) | (state_d == INST_LOAD) |
                     (state_d == IDLE) |
                     (aluop & ((state_d == OP_FETCH) | (state_d == ALU_OP) |
                               (state_d == STORE)));
    strb_d.load_ir = (state_d == INST_LOAD) | (state_d == IDLE);
    strb_d.halt    = ((state_d == OP_ADDR) & (opcode == HLT)) |
                     (state_d == HALTED);
    strb_d.inc_pc  = (state_d == OP_ADDR) |
                     ((state_d == ALU_OP) & (opcode == SKZ) & zero);
    strb_d.load_ac = aluop & ((state_d == ALU_OP) | (state_d == STORE));
    strb_d.load_pc = (opcode == JMP) & ((state_d == ALU_OP) | (state_d == STORE));
    strb_d.mem_wr  = (state_d == STORE) & (opcode == STO);
    done_d         = (state_d == STORE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q <= INST_ADDR;
      strb_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      strb_q  <= strb_d;
      done_q  <= done_d;
    end
  end

  assign phase      = state_q;
  assign instr_done = done_q;
  assign mem_rd     = strb_q.mem_rd;
  assign load_ir    = strb_q.load_ir;
  assign halt       = strb_q.halt;
  assign inc_pc     = strb_q.inc_pc;
  assign load_ac    = strb_q.load_ac;
  assign load_pc    = strb_q.load_pc;
  assign mem_wr     = strb_q.mem_wr;

endmodule

// File: tb/tb_control_seq_ws.sv
// Bench for control_seq_ws: two instances (A: no static wait, ready handshake;
// B: three wait states, handshake off) checked cycle by cycle against an
// expected phase trace built per instruction from the sequencing rules.
module tb_control_seq_ws;
  import control_seq_ws_pkg::*;

  localparam int unsigned W_A = 0;
  localparam int unsigned W_B = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rst_b;
  opcode_t     op_a, op_b;
  logic        zero_a, zero_b, rdy_a, rdy_b, res_a, res_b, stp_a, stp_b;
  logic [6:0]  strb_a, strb_b;
  ctrl_state_t ph_a, ph_b;
  logic        done_a, done_b;

  int n_vec = 0;
  int n_bad = 0;

  control_seq_ws #(.MEM_WAIT(W_A), .USE_READY(1), .CNT_W(4)) u_dut_a (
    .clk(clk), .rst_(rst_a), .opcode(op_a), .zero(zero_a), .mem_ready(rdy_a),
    .resume(res_a), .step_mode(stp_a),
    .mem_rd(strb_a[6]), .load_ir(strb_a[5]), .halt(strb_a[4]), .inc_pc(strb_a[3]),
    .load_ac(strb_a[2]), .load_pc(strb_a[1]), .mem_wr(strb_a[0]),
    .phase(ph_a), .instr_done(done_a)
  );

  control_seq_ws #(.MEM_WAIT(W_B), .USE_READY(0), .CNT_W(4)) u_dut_b (
    .clk(clk), .rst_(rst_b), .opcode(op_b), .zero(zero_b), .mem_ready(rdy_b),
    .resume(res_b), .step_mode(stp_b),
    .mem_rd(strb_b[6]), .load_ir(strb_b[5]), .halt(strb_b[4]), .inc_pc(strb_b[3]),
    .load_ac(strb_b[2]), .load_pc(strb_b[1]), .mem_wr(strb_b[0]),
    .phase(ph_b), .instr_done(done_b)
  );

  // Expected trace of one instruction: phase, mem_ready and resume per cycle.
  ctrl_state_t eq[$];
  bit          rq[$];
  bit          resq[$];

  // {mem_rd,load_ir,halt,inc_pc,load_ac,load_pc,mem_wr} per phase.
  function automatic logic [6:0] ref_strb(ctrl_state_t p, opcode_t op, logic z);
    bit alu, jmp;
    alu = (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
    jmp = (op == JMP);
    case (p)
      INST_FETCH:      return 7'b1000000;
      INST_LOAD, IDLE: return 7'b1100000;
      OP_ADDR:         return (op == HLT) ? 7'b0011000 : 7'b0001000;
      OP_FETCH:        return alu ? 7'b1000000 : 7'b0000000;
      ALU_OP:          return {alu, 2'b00, (op == SKZ) && z, alu, jmp, 1'b0};
      STORE:           return {alu, 3'b000, alu, jmp, op == STO};
      HALTED:          return 7'b0010000;
      default:         return 7'b0000000;
    endcase
  endfunction

  function automatic int imax(int a, int b);
    return (a > b) ? a : b;
  endfunction

  task automatic push(ctrl_state_t p, bit r, bit res);
    eq.push_back(p);
    rq.push_back(r);
    resq.push_back(res);
  endtask

  // A fetch phase lasts max(wait, ready-low cycles)+1 cycles.
  task automatic push_fetch(ctrl_state_t p, int w, bit ur, int r);
    int len;
    len = ur ? imax(w, r) + 1 : w + 1;
    for (int i = 0; i < len; i++)
      push(p, ur ? (i >= r) : 1'($urandom % 2), 1'($urandom % 2));
  endtask

  task automatic build(int w, bit ur, opcode_t op, bit step, int r_inst, int r_op, int hold);
    eq.delete(); rq.delete(); resq.delete();
    push(INST_ADDR, 1'b1, 1'($urandom % 2));
    push_fetch(INST_FETCH, w, ur, r_inst);
    push(INST_LOAD, 1'b1, 1'($urandom % 2));
    push(IDLE, 1'b1, 1'($urandom % 2));
    push(OP_ADDR, 1'b1, 1'($urandom % 2));
    if (op == HLT) begin
      for (int i = 0; i <= hold; i++) push(HALTED, 1'b1, i == hold);
    end else begin
      push_fetch(OP_FETCH, w, ur, r_op);
      push(ALU_OP, 1'b1, 1'($urandom % 2));
      push(STORE, 1'b1, 1'($urandom % 2));
      if (step)
        for (int i = 0; i <= hold; i++) push(PAUSED, 1'b1, i == hold);
    end
  endtask

  // Run one instruction on DUT sel, starting with the DUT in INST_ADDR.
  task automatic run_instr(int sel, opcode_t op, bit z, bit step, int r_inst, int r_op, int hold);
    ctrl_state_t ph;
    logic [6:0]  st, exp_st;
    logic        dn;
    bit          stp;
    build(sel ? int'(W_B) : int'(W_A), sel == 0, op, step, r_inst, r_op, hold);
    if (sel == 0) begin op_a = op; zero_a = z; end
    else          begin op_b = op; zero_b = z; end
    for (int k = 0; k < eq.size(); k++) begin
      ph = sel ? ph_b : ph_a;
      st = sel ? strb_b : strb_a;
      dn = sel ? done_b : done_a;
      exp_st = ref_strb(eq[k], op, z);
      n_vec++;
      if (ph !== eq[k]) begin
        n_bad++;
        $display("FAIL phase dut%0d %s cyc %0d: got %s exp %s", sel, op.name(), k, ph.name(), eq[k].name());
      end
      n_vec++;
      if (st !== exp_st) begin
        n_bad++;
        $display("FAIL strobes dut%0d %s z=%0d cyc %0d (%s): got %b exp %b", sel, op.name(), z, k, eq[k].name(), st, exp_st);
      end
      n_vec++;
      if (dn !== (eq[k] == STORE)) begin
        n_bad++;
        $display("FAIL instr_done dut%0d %s cyc %0d: got %b exp %b", sel, op.name(), k, dn, eq[k] == STORE);
      end
      // PAUSED must not be released by dropping step_mode.
      stp = (eq[k] == PAUSED) ? 1'($urandom % 2) : step;
      if (sel == 0) begin rdy_a = rq[k]; res_a = resq[k]; stp_a = stp; end
      else          begin rdy_b = rq[k]; res_b = resq[k]; stp_b = stp; end
      @(posedge clk); #1;
    end
  endtask

  // Reset hold with resume asserted; returns at a falling edge after release.
  task automatic test_reset(int sel);
    ctrl_state_t ph;
    logic [6:0]  st;
    logic        dn;
    if (sel == 0) begin rst_a = 1'b0; res_a = 1'b1; end
    else          begin rst_b = 1'b0; res_b = 1'b1; end
    #1;
    for (int c = 0; c < 3; c++) begin
      ph = sel ? ph_b : ph_a;
      st = sel ? strb_b : strb_a;
      dn = sel ? done_b : done_a;
      n_vec++;
      if (ph !== INST_ADDR || st !== 7'b0 || dn !== 1'b0) begin
        n_bad++;
        $display("FAIL reset dut%0d cyc %0d: got %s/%b/%b exp INST_ADDR/0000000/0", sel, c, ph.name(), st, dn);
      end
      if (sel == 0) op_a = opcode_t'(3'($urandom_range(0, 7)));
      else          op_b = opcode_t'(3'($urandom_range(0, 7)));
      @(posedge clk); #1;
    end
    @(negedge clk);
    if (sel == 0) begin rst_a = 1'b1; res_a = 1'b0; end
    else          begin rst_b = 1'b1; res_b = 1'b0; end
  endtask

  task automatic test_decode();
    for (int o = 0; o < 8; o++)
      for (int z = 0; z < 2; z++)
        run_instr(0, opcode_t'(3'(o)), 1'(z), 1'b0, 0, 0, 2);
  endtask

  task automatic test_ready();
    run_instr(0, LDA, 1'b0, 1'b0, 0, 5, 0);
    run_instr(0, STO, 1'b1, 1'b0, 4, 2, 0);
    run_instr(0, ADD, 1'b0, 1'b0, 1, 1, 0);
  endtask

  task automatic test_halt(int sel);
    run_instr(sel, HLT, 1'b0, 1'b0, 0, 0, 20);
    run_instr(sel, JMP, 1'b1, 1'b0, 0, 0, 0);
  endtask

  task automatic test_step(int sel);
    run_instr(sel, STO, 1'b0, 1'b1, 0, 0, 6);
    run_instr(sel, SKZ, 1'b1, 1'b1, 1, 0, 0);
    run_instr(sel, XOR, 1'b0, 1'b0, 0, 0, 0);
  endtask

  task automatic test_wait_states();
    run_instr(1, LDA, 1'b0, 1'b0, 0, 0, 0);
    run_instr(1, LDA, 1'b1, 1'b0, 0, 0, 0);
    run_instr(1, SKZ, 1'b1, 1'b0, 0, 0, 0);
  endtask

  // Async reset in the middle of the OP_FETCH stall, then a full clean instruction.
  task automatic test_reset_mid_stall();
    op_b = LDA; stp_b = 1'b0; res_b = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    n_vec++;
    if (ph_b !== OP_FETCH) begin
      n_bad++;
      $display("FAIL stall_entry: got %s exp OP_FETCH", ph_b.name());
    end
    #2 rst_b = 1'b0;
    #1;
    n_vec++;
    if (ph_b !== INST_ADDR || strb_b !== 7'b0 || done_b !== 1'b0) begin
      n_bad++;
      $display("FAIL async_reset: got %s/%b/%b exp INST_ADDR/0000000/0", ph_b.name(), strb_b, done_b);
    end
    @(negedge clk);
    rst_b = 1'b1;
    run_instr(1, LDA, 1'b0, 1'b0, 0, 0, 0);
  endtask

  task automatic test_random(int sel, int n);
    for (int i = 0; i < n; i++)
      run_instr(sel, opcode_t'(3'($urandom_range(0, 7))), 1'($urandom % 2),
                ($urandom % 4) == 0, $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 4));
  endtask

  initial begin
    rst_a = 1'b0; rst_b = 1'b0;
    op_a = HLT; op_b = HLT;
    zero_a = 1'b0; zero_b = 1'b0;
    rdy_a = 1'b1; rdy_b = 1'b1;
    res_a = 1'b0; res_b = 1'b0;
    stp_a = 1'b0; stp_b = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset(0);
    test_decode();
    test_ready();
    test_halt(0);
    test_step(0);
    test_random(0, 40);
    test_reset(1);
    test_wait_states();
    test_step(1);
    test_halt(1);
    test_reset_mid_stall();
    test_random(1, 40);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
